// File: rtl/parking_checkin_if.sv
// Arrival/release handshake shared by the requester,
// the checkout side and the check-in slot allocator.
interface parking_checkin_if;
   logic       enter_req;
   logic       release_valid;
   logic [3:0] release_slot;
   logic       enter_ack;
   logic       enter_nack;
   logic [3:0] slot_id;
   logic       busy;

   modport master (
      output enter_req,
      output release_valid,
      output release_slot,
      input  enter_ack,
      input  enter_nack,
      input  slot_id,
      input  busy
   );

   modport slave (
      input  enter_req,
      input  release_valid,
      input  release_slot,
      output enter_ack,
      output enter_nack,
      output slot_id,
      output busy
   );
endinterface

// File: rtl/parking_checkin.sv
// Entry-side slot allocator: lowest-first scan, entry
// timestamps, occupancy map and the shared time base.
module parking_checkin #(
   parameter int NUM_SLOTS = 6,
   parameter int TIME_W    = 11
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        tick,
   parking_checkin_if.slave            io,
   output logic [TIME_W-1:0]           timer,
   output logic [NUM_SLOTS-1:0]        occupied,
   output logic [NUM_SLOTS*TIME_W-1:0] entry_times,
   output logic [3:0]                  count
);

   localparam logic [3:0] LP_LAST = 4'(NUM_SLOTS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_GRANT,
      S_REJECT
   } state_t;

   state_t                           r_state;
   state_t                           w_next;
   logic [3:0]                       r_idx;
   logic [3:0]                       r_count;
   logic [3:0]                       r_slot_id;
   logic [TIME_W-1:0]                r_timer;
   logic [NUM_SLOTS-1:0]             r_occ;
   logic [NUM_SLOTS-1:0][TIME_W-1:0] r_times;
   logic [NUM_SLOTS-1:0]             w_idx_hit;
   logic [NUM_SLOTS-1:0]             w_rel_mask;
   logic [NUM_SLOTS-1:0]             w_claim_mask;
   logic                             w_cur_occ;
   logic                             w_claim;
   logic                             w_rel;

   // One-hot decode of scan index and of a legal release
   always_comb begin
      w_idx_hit  = '0;
      w_rel_mask = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         w_idx_hit[i]  = (r_idx == 4'(i + 1));
         w_rel_mask[i] = io.release_valid
                      && (io.release_slot == 4'(i + 1))
                      && r_occ[i];
      end
   end

   assign w_cur_occ    = |(w_idx_hit & r_occ);
   assign w_rel        = |w_rel_mask;
   assign w_claim_mask = w_claim ? w_idx_hit : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_claim       = 1'b0;
      io.enter_ack  = 1'b0;
      io.enter_nack = 1'b0;
      io.busy       = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            io.busy = 1'b0;
            if (io.enter_req)
               w_next = (r_count == LP_LAST) ? S_REJECT : S_SCAN;
         end
         S_SCAN: begin
            if (!w_cur_occ) begin
               w_claim = 1'b1;
               w_next  = S_GRANT;
            end else if (r_idx == LP_LAST) begin
               w_next = S_REJECT;
            end
         end
         S_GRANT: begin
            io.enter_ack = 1'b1;
            w_next       = S_IDLE;
         end
         S_REJECT: begin
            io.enter_nack = 1'b1;
            w_next        = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_idx <= 4'd1;
      else if (r_state == S_IDLE) r_idx <= 4'd1;
      else if (r_state == S_SCAN) r_idx <= r_idx + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_timer <= '0;
      else if (tick) r_timer <= r_timer + 1'b1;
   end

   // Claim and release never hit the same slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ     <= '0;
         r_times   <= '0;
         r_count   <= '0;
         r_slot_id <= '0;
      end else begin
         r_occ   <= (r_occ | w_claim_mask) & ~w_rel_mask;
         r_count <= r_count + {3'b0, w_claim} - {3'b0, w_rel};
         if (w_claim) r_slot_id <= r_idx;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_claim_mask[i])    r_times[i] <= r_timer;
            else if (w_rel_mask[i]) r_times[i] <= '0;
         end
      end
   end

   assign io.slot_id  = r_slot_id;
   assign timer       = r_timer;
   assign occupied    = r_occ;
   assign entry_times = r_times;
   assign count       = r_count;

endmodule

// File: doc/parking_checkin.md
# parking_checkin

Entry-side companion to the parking checkout logic. On a car-arrival request it scans the slot table lowest-first, claims the first free slot, stamps it with the current parking-time counter and reports the slot number. It owns the free-running time base, the per-slot entry timestamps and the occupancy map that the checkout side reads. It accepts slot-release commands from the checkout side.

## Interface
Parameters:
- NUM_SLOTS, 6, number of parking slots; slots are numbered 1..NUM_SLOTS, max 15
- TIME_W, 11, width of the time counter and the stored timestamps

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  time-base enable; timer increments on each clk edge where tick=1
- enter_req  in  1  car-arrival request, sampled only in IDLE
- release_valid  in  1  free the slot named by release_slot
- release_slot  in  4  slot to free, 1..NUM_SLOTS
- timer  out  TIME_W  current time-base value
- enter_ack  out  1  one-cycle pulse: slot granted
- enter_nack  out  1  one-cycle pulse: lot full, no slot granted
- slot_id  out  4  granted slot, valid while enter_ack=1, otherwise holds last grant
- busy  out  1  high whenever the FSM is not in IDLE
- occupied  out  NUM_SLOTS  bit i-1 set = slot i occupied
- entry_times  out  NUM_SLOTS*TIME_W  slot i timestamp in bits [i*TIME_W-1 : (i-1)*TIME_W]
- count  out  4  number of occupied slots

## Operation
- FSM states: IDLE, SCAN, GRANT, REJECT.
- IDLE: when enter_req=1 and count==NUM_SLOTS, go to REJECT. When enter_req=1 and count<NUM_SLOTS, go to SCAN with scan index=1. Otherwise stay in IDLE.
- SCAN: test one slot per cycle against the live occupied bit.
  - If the slot is free: set its occupied bit, write entry_times[slot] = current timer value (pre-tick), latch slot_id, go to GRANT.
  - If index==NUM_SLOTS and that slot is occupied: go to REJECT.
  - Otherwise index+1.
- GRANT: enter_ack=1 for exactly one cycle, then IDLE.
- REJECT: enter_nack=1 for exactly one cycle, then IDLE.
- enter_req outside IDLE is ignored. It is not queued. Requests are level-sampled, so a requester holding enter_req high gets a new transaction every time the FSM returns to IDLE.
- Release path, independent of the FSM and active in every state:
  - release_valid=1 with release_slot in 1..NUM_SLOTS and that slot occupied: clear its occupied bit and zero its timestamp at the next edge.
  - release_slot of 0, greater than NUM_SLOTS, or an already-free slot: ignored, no state change.
- Simultaneous claim and release of different slots in the same edge: both take effect and count is unchanged.
- A release cannot target the slot being claimed, because that slot is free.
- A release of a slot the scan has already passed is not reconsidered during the current scan.
- count: +1 on claim, −1 on valid release, net 0 when both happen on the same edge.
- Timer: TIME_W-bit unsigned, wraps from 2^TIME_W−1 to 0. Wrap handling for elapsed time (modulo subtraction) belongs to the checkout side. This block stores raw values.

## Timing
- Reset values: timer=0, occupied=0, entry_times=0, count=0, slot_id=0, enter_ack=0, enter_nack=0, busy=0, FSM=IDLE.
- Reset asserted mid-scan aborts the transaction. No ack or nack is issued afterwards.
- Let cycle 0 be the cycle where enter_req is sampled in IDLE:
  - Slot k is checked in cycle k.
  - If slot k is the first free slot, enter_ack, slot_id=k and occupied bit k are all visible in cycle k+1.
  - Grant latency is k+1 cycles, worst case NUM_SLOTS+1.
- Full detected at request time: enter_nack in cycle 1.
- Full discovered by the scan (a slot filled or freed state changed during the scan): enter_nack in cycle NUM_SLOTS+1.
- busy is high from cycle 1 through the ack/nack cycle inclusive. The earliest next request is sampled in the cycle after ack/nack.
- Recorded timestamp = timer value during the SCAN cycle that finds the slot. A tick in that same cycle does not affect the stored value.
- Release effects are visible one cycle after release_valid.

## Test plan
- Reset, then tick 5 times, then pulse enter_req: ack in cycle 2 with slot_id=1, occupied=6'b000001, entry_times slot1=5, count=1.
- Occupy slots 1,2,4, then request: scan passes slots 1 and 2, ack in cycle 4 with slot_id=3, count=4.
- Fill all 6 slots, then request: enter_nack in cycle 1, no state change. Then release slot 5: occupied bit 4 clears next cycle, count=5. A new request gets slot_id=5.
- Slots 1–5 occupied and slot 6 free: request, and in cycle 2 release slot 1. The scan still grants slot 6 (ack in cycle 7). count goes 5→4→5.
- Preload timer to 2047, tick once, then request: timer=0 and the stored timestamp is 0. Release of slot 0, slot 7, or a free slot produces no change.
- Assert rst_n=0 during cycle 3 of a scan: all outputs return to reset values, no ack follows after rst_n is released.
